// File: rtl/atx_pll_seq_if.sv
// Signal bundle between the ATX PLL sequencer, the PLL hard block and the TX reset controller.
interface atx_pll_seq_if;
  logic       restart;
  logic       pll_locked;
  logic       pll_cal_busy;
  logic       pll_powerdown;
  logic       pll_ready;
  logic       fault;
  logic       lol_pulse;
  logic [3:0] retry_cnt;
  logic [2:0] seq_state;

  modport master (
    output restart, pll_locked, pll_cal_busy,
    input  pll_powerdown, pll_ready, fault, lol_pulse, retry_cnt, seq_state
  );

  modport slave (
    input  restart, pll_locked, pll_cal_busy,
    output pll_powerdown, pll_ready, fault, lol_pulse, retry_cnt, seq_state
  );
endinterface

// File: rtl/atx_pll_seq.sv
// Power-up / recovery sequencer for the 10G ATX transmit PLL: powerdown hold, calibration wait,
// lock qualification, loss-of-lock monitoring and bounded automatic retry.
module atx_pll_seq #(
  parameter int PWRDN_CYCLES = 1000,
  parameter int CAL_TIMEOUT  = 2000000,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int LOCK_STABLE  = 4096,
  parameter int UNLOCK_FILT  = 16,
  parameter int MAX_RETRY    = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  atx_pll_seq_if.slave bus
);

  localparam int MAX_A = (PWRDN_CYCLES > CAL_TIMEOUT) ? PWRDN_CYCLES : CAL_TIMEOUT;
  localparam int MAX_B = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > UNLOCK_FILT) ? MAX_C : UNLOCK_FILT;
  localparam int CNT_W = $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] PWRDN_LAST  = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'(CAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCKTO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_FILT - 1);
  localparam logic [4:0]       RETRY_MAX   = 5'(MAX_RETRY);

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    WAIT_CAL  = 3'd1,
    WAIT_LOCK = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Retry counter holds at its maximum instead of wrapping back to zero.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             lock_sync_p0, locked_s;
  logic             cal_sync_p0, cal_busy_s;
  logic             pd_q, ready_q, fault_q;
  logic             lol, fail;

  // Two-flop synchronisers; cal_busy resets high so nothing is decided before real data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_p0 <= 1'b0;
      locked_s     <= 1'b0;
      cal_sync_p0  <= 1'b1;
      cal_busy_s   <= 1'b1;
    end else begin
      lock_sync_p0 <= bus.pll_locked;
      locked_s     <= lock_sync_p0;
      cal_sync_p0  <= bus.pll_cal_busy;
      cal_busy_s   <= cal_sync_p0;
    end
  end

  // Next-state, counter and retry logic; a failed attempt and restart override the per-state result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    retry_d = retry_q;
    lol     = 1'b0;
    fail    = 1'b0;
    unique case (state_q)
      PWRDN: begin
        if (cnt_q == PWRDN_LAST) begin
          state_d = WAIT_CAL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      WAIT_CAL: begin
        if (!cal_busy_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else if (cnt_q == CAL_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      WAIT_LOCK: begin
        tcnt_d = tcnt_q + ONE;
        // A qualified lock wins over a timeout landing on the same cycle.
        if (locked_s && (cnt_q == STABLE_LAST)) begin
          state_d = READY;
          cnt_d   = '0;
          tcnt_d  = '0;
        end else begin
          cnt_d = locked_s ? cnt_q + ONE : '0;
          if (tcnt_q == LOCKTO_LAST) fail = 1'b1;
        end
      end
      READY: begin
        if (locked_s) begin
          cnt_d = '0;
        end else if (cnt_q == UNLOCK_LAST) begin
          lol  = 1'b1;
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PWRDN;
        cnt_d   = '0;
      end
    endcase
    if (fail) begin
      retry_d = sat_inc4(retry_q);
      cnt_d   = '0;
      tcnt_d  = '0;
      state_d = ({1'b0, retry_d} > RETRY_MAX) ? FAULT : PWRDN;
    end
    if (bus.restart) begin
      state_d = PWRDN;
      cnt_d   = '0;
      tcnt_d  = '0;
      retry_d = '0;
      lol     = 1'b0;
    end
  end

  // State, counters and registered PLL-facing outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWRDN;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      retry_q <= '0;
      pd_q    <= 1'b1;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      retry_q <= retry_d;
      pd_q    <= (state_d == PWRDN) || (state_d == FAULT);
      ready_q <= (state_d == READY);
      fault_q <= (state_d == FAULT);
    end
  end

  assign bus.pll_powerdown = pd_q;
  assign bus.pll_ready     = ready_q;
  assign bus.fault         = fault_q;
  assign bus.lol_pulse     = lol;
  assign bus.retry_cnt     = retry_q;
  assign bus.seq_state     = state_q;

endmodule

// File: tb/tb_atx_pll_seq.sv
// Directed bench for atx_pll_seq with a queue-based expected-value scoreboard.
module tb_atx_pll_seq;
  localparam int PWRDN   = 20;
  localparam int CAL_TO  = 30;
  localparam int LOCK_TO = 120;
  localparam int LS      = 16;
  localparam int UF      = 4;
  localparam int MAXR    = 7;

  localparam logic [2:0] S_PWRDN = 3'd0;
  localparam logic [2:0] S_CAL   = 3'd1;
  localparam logic [2:0] S_LOCK  = 3'd2;
  localparam logic [2:0] S_READY = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  atx_pll_seq_if bus();

  atx_pll_seq #(
    .PWRDN_CYCLES(PWRDN),
    .CAL_TIMEOUT (CAL_TO),
    .LOCK_TIMEOUT(LOCK_TO),
    .LOCK_STABLE (LS),
    .UNLOCK_FILT (UF),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  string       exp_tag_q[$];
  logic [31:0] exp_val_q[$];

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(val);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    checks++;
    if (exp_val_q.size() == 0) begin
      tag = "sb_underflow";
      exp = 32'hDEAD_BEEF;
    end else begin
      tag = exp_tag_q.pop_front();
      exp = exp_val_q.pop_front();
    end
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int max, output int n);
    n = 0;
    while (bus.seq_state !== tgt && n < max) begin
      tick(1);
      n++;
    end
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, tot, lol_cnt, lol_at, rdy_fall_at;
    logic saw_lol, left_ready;

    bus.restart      = 1'b0;
    bus.pll_locked   = 1'b0;
    bus.pll_cal_busy = 1'b1;
    tick(3);

    // Reset values
    sb_push("rst_state", S_PWRDN);  sb_check(bus.seq_state);
    sb_push("rst_pd", 1);           sb_check(bus.pll_powerdown);
    sb_push("rst_ready", 0);        sb_check(bus.pll_ready);
    sb_push("rst_fault", 0);        sb_check(bus.fault);
    sb_push("rst_lol", 0);          sb_check(bus.lol_pulse);
    sb_push("rst_retry", 0);        sb_check(bus.retry_cnt);

    // Nominal power-up
    rst_n = 1'b1;
    tot   = 0;
    n     = 0;
    while (bus.pll_powerdown === 1'b1 && n < 4 * PWRDN) begin
      tick(1);
      n++;
    end
    sb_push("pwrdn_len", PWRDN);    sb_check(n);
    tot += n;
    tick(10);
    tot += 10;
    bus.pll_cal_busy = 1'b0;
    sb_push("cal_hold_state", S_CAL); sb_check(bus.seq_state);
    wait_state(S_LOCK, 50, n);
    sb_push("cal_done_lat", 3);     sb_check(n);
    tot += n;
    tick(5);
    tot += 5;
    bus.pll_locked = 1'b1;
    wait_state(S_READY, 4 * LS, n);
    sb_push("lock_qual_lat", LS + 2); sb_check(n);
    tot += n;
    sb_push("nom_ready", 1);        sb_check(bus.pll_ready);
    sb_push("nom_pd", 0);           sb_check(bus.pll_powerdown);
    sb_push("nom_retry", 0);        sb_check(bus.retry_cnt);
    sb_push("ready_bound", 1);      sb_check(tot >= PWRDN + LS + 2);

    // Loss of lock: short drop is filtered, full-length drop re-sequences
    tick(5);
    saw_lol    = 1'b0;
    left_ready = 1'b0;
    for (int i = 0; i < UF + 10; i++) begin
      bus.pll_locked = (i >= UF - 1);
      tick(1);
      if (bus.lol_pulse !== 1'b0) saw_lol = 1'b1;
      if (bus.seq_state !== S_READY) left_ready = 1'b1;
    end
    sb_push("short_drop_lol", 0);   sb_check(saw_lol);
    sb_push("short_drop_ready", 0); sb_check(left_ready);

    lol_cnt     = 0;
    lol_at      = -1;
    rdy_fall_at = -1;
    bus.pll_locked = 1'b0;
    for (int i = 1; i <= UF + 6; i++) begin
      tick(1);
      if (bus.lol_pulse === 1'b1) begin
        lol_cnt++;
        if (lol_at < 0) lol_at = i;
      end
      if (bus.pll_ready !== 1'b1 && rdy_fall_at < 0) rdy_fall_at = i;
    end
    sb_push("lol_count", 1);        sb_check(lol_cnt);
    sb_push("lol_cycle", UF + 1);   sb_check(lol_at);
    sb_push("ready_fall", UF + 2);  sb_check(rdy_fall_at);
    sb_push("lol_state", S_PWRDN);  sb_check(bus.seq_state);
    sb_push("lol_retry", 1);        sb_check(bus.retry_cnt);

    // Lock chatter: stability counter restarts on each drop
    wait_state(S_LOCK, PWRDN + 20, n);
    sb_push("relock_enter", S_LOCK); sb_check(bus.seq_state);
    for (int k = 0; k < 3; k++) begin
      bus.pll_locked = 1'b1;
      tick(10);
      bus.pll_locked = 1'b0;
      tick(10);
    end
    sb_push("chatter_state", S_LOCK); sb_check(bus.seq_state);
    sb_push("chatter_ready", 0);    sb_check(bus.pll_ready);
    bus.pll_locked = 1'b1;
    wait_state(S_READY, 4 * LS, n);
    sb_push("chatter_qual_lat", LS + 2); sb_check(n);
    sb_push("chatter_retry", 1);    sb_check(bus.retry_cnt);

    // Restart from READY, then plain lock timeout, then restart colliding with timeout
    bus.pll_locked = 1'b0;
    pulse_restart();
    sb_push("rst_from_ready_state", S_PWRDN); sb_check(bus.seq_state);
    sb_push("rst_from_ready_retry", 0);       sb_check(bus.retry_cnt);
    sb_push("rst_from_ready_rdy", 0);         sb_check(bus.pll_ready);
    wait_state(S_LOCK, PWRDN + 20, n);
    tick(LOCK_TO - 1);
    sb_push("lockto_hold", S_LOCK); sb_check(bus.seq_state);
    tick(1);
    sb_push("lockto_state", S_PWRDN); sb_check(bus.seq_state);
    sb_push("lockto_retry", 1);     sb_check(bus.retry_cnt);
    wait_state(S_LOCK, PWRDN + 20, n);
    tick(LOCK_TO - 1);
    pulse_restart();
    sb_push("collide_state", S_PWRDN); sb_check(bus.seq_state);
    sb_push("collide_retry", 0);    sb_check(bus.retry_cnt);

    // Calibration timeout until FAULT
    bus.pll_cal_busy = 1'b1;
    for (int a = 1; a <= MAXR + 1; a++) begin
      wait_state(S_CAL, PWRDN + 10, n);
      n = 0;
      while (bus.seq_state === S_CAL && n < 2 * CAL_TO) begin
        tick(1);
        n++;
      end
      if (a == 1) begin
        sb_push("cal_to_len", CAL_TO); sb_check(n);
      end
      sb_push("cal_fail_retry", a);  sb_check(bus.retry_cnt);
      sb_push("cal_fail_state", (a <= MAXR) ? S_PWRDN : S_FAULT); sb_check(bus.seq_state);
    end
    sb_push("fault_flag", 1);       sb_check(bus.fault);
    sb_push("fault_pd", 1);         sb_check(bus.pll_powerdown);
    sb_push("fault_ready", 0);      sb_check(bus.pll_ready);
    tick(50);
    sb_push("fault_sticky", S_FAULT); sb_check(bus.seq_state);
    pulse_restart();
    sb_push("fault_rs_state", S_PWRDN); sb_check(bus.seq_state);
    sb_push("fault_rs_retry", 0);   sb_check(bus.retry_cnt);
    sb_push("fault_rs_fault", 0);   sb_check(bus.fault);
    sb_push("fault_rs_pd", 1);      sb_check(bus.pll_powerdown);

    // Asynchronous reset while READY
    bus.pll_cal_busy = 1'b0;
    bus.pll_locked   = 1'b1;
    wait_state(S_READY, PWRDN + LS + 40, n);
    sb_push("pre_areset_ready", 1); sb_check(bus.pll_ready);
    #2;
    rst_n = 1'b0;
    #1;
    sb_push("areset_ready", 0);     sb_check(bus.pll_ready);
    sb_push("areset_pd", 1);        sb_check(bus.pll_powerdown);
    sb_push("areset_state", S_PWRDN); sb_check(bus.seq_state);
    sb_push("areset_lol", 0);       sb_check(bus.lol_pulse);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
